ysyx_23060203_ifu: RTL and testbench

//  Instruction fetch unit; the producer side of the decoder's inst/pc input.

---
 rtl/ysyx_23060203_ifu.sv | 134 +++++++++++++
 tb/tb_ysyx_23060203_ifu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_ifu.sv
// ysyx_23060203_ifu: fetch FSM, AR/R read port, {inst,pc} to decoder.
// Ports: clk/rst, ifu_ar*/ifu_r* bus, inst/pc/out_* out, dnpc_* in, perf_*.
// Macro YSYX_23060203_IFU_PERF_EN adds fetch and bus-stall counters.
module ysyx_23060203_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] dnpc,
  input  logic        dnpc_valid,
  output logic        dnpc_ready,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  typedef enum logic [1:0] {
    S_REQ,
    S_RESP,
    S_OUT,
    S_NPC
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  logic ar_fire;
  logic r_fire;

  assign ar_fire = (state_q == S_REQ) && ifu_arready;
  assign r_fire  = (state_q == S_RESP) && ifu_rvalid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      S_REQ: begin
        if (ifu_arready) state_d = S_RESP;
      end
      S_RESP: begin
        if (ifu_rvalid) begin
          inst_d  = ifu_rdata;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_NPC;
      end
      S_NPC: begin
        if (dnpc_valid) begin
          pc_d    = dnpc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // pc keeps dnpc[1:0]; only the bus address is word aligned
  assign ifu_araddr  = {pc_q[31:2], 2'b00};
  assign ifu_arvalid = (state_q == S_REQ);
  assign ifu_rready  = (state_q == S_RESP);
  assign out_valid   = (state_q == S_OUT);
  assign dnpc_ready  = (state_q == S_NPC);
  assign inst        = inst_q;
  assign pc          = pc_q;

  // response code is not acted on
  logic unused_rresp;
  assign unused_rresp = ^ifu_rresp;

`ifdef YSYX_23060203_IFU_PERF_EN
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stall_q, stall_d;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == S_REQ) && !ifu_arready) ||
                     ((state_q == S_RESP) && !ifu_rvalid);

  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    if (r_fire)    fetch_d = fetch_q + 32'd1;
    if (stall_cyc) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 32'h0;
      stall_q <= 32'h0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign perf_fetch = fetch_q;
  assign perf_stall = stall_q;

  logic unused_ar;
  assign unused_ar = ar_fire;
`else
  assign perf_fetch = 32'h0;
  assign perf_stall = 32'h0;

  logic unused_fire;
  assign unused_fire = ar_fire ^ r_fire;
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// tb_ysyx_23060203_ifu: cycle vector table plus a 10-instruction run.
// Checks handshakes, pc/inst holding, reset and perf counters.
module tb_ysyx_23060203_ifu;

`ifdef YSYX_23060203_IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef enum int { REQ, RSP, OUT, NPC } st_e;

  typedef struct {
    logic        rst;
    logic        ar;
    logic        rv;
    logic [31:0] rdata;
    logic        ordy;
    logic        dv;
    logic [31:0] dnpc;
    st_e         st;
    logic [31:0] inst;
    logic [31:0] pc;
    int          f;
    int          s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic        dnpc_ready;
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_23060203_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .inst        (inst),
    .pc          (pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dnpc        (dnpc),
    .dnpc_valid  (dnpc_valid),
    .dnpc_ready  (dnpc_ready),
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall)
  );

  task automatic chk(input string nm, input int row,
                     input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic v,
                              input logic [31:0] rd, input logic o,
                              input logic d, input logic [31:0] np,
                              input st_e st, input logic [31:0] ei,
                              input logic [31:0] ep, input int f,
                              input int s);
    vec_t x;
    x.rst = r; x.ar = a; x.rv = v; x.rdata = rd;
    x.ordy = o; x.dv = d; x.dnpc = np;
    x.st = st; x.inst = ei; x.pc = ep; x.f = f; x.s = s;
    return x;
  endfunction

  vec_t vq[$];

  initial begin
    rst = 1'b1;
    ifu_arready = 1'b0;
    ifu_rdata = 32'h0;
    ifu_rresp = 2'b00;
    ifu_rvalid = 1'b0;
    out_ready = 1'b0;
    dnpc = 32'h0;
    dnpc_valid = 1'b0;

    // rst ar rv rdata ordy dv dnpc | state inst pc fetch stall
    vq.push_back(mk(1,0,0,32'h0,0,0,32'h0, REQ,32'h0,BASE,0,0));
    // back-to-back loop
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000004, RSP,32'h0,BASE,0,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000004, OUT,32'h13,BASE,1,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000004, NPC,32'h13,BASE,1,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000004, REQ,32'h13,32'h80000004,1,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000008, RSP,32'h13,32'h80000004,1,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000008, OUT,32'h13,32'h80000004,2,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000008, NPC,32'h13,32'h80000004,2,0));
    vq.push_back(mk(0,1,1,32'h13,1,1,32'h80000008, REQ,32'h13,32'h80000008,2,0));
    // arready late by 3; stray rvalid in S_REQ not consumed
    vq.push_back(mk(0,0,1,32'hdeadbeef,1,1,32'h0, REQ,32'h13,32'h80000008,2,1));
    vq.push_back(mk(0,0,1,32'hdeadbeef,1,1,32'h0, REQ,32'h13,32'h80000008,2,2));
    vq.push_back(mk(0,0,1,32'hdeadbeef,1,1,32'h0, REQ,32'h13,32'h80000008,2,3));
    vq.push_back(mk(0,1,1,32'hdeadbeef,0,0,32'h0, RSP,32'h13,32'h80000008,2,3));
    vq.push_back(mk(0,0,1,32'h00100093,0,0,32'h0, OUT,32'h00100093,32'h80000008,3,3));
    // decoder stalls 5 cycles; dnpc_valid ignored meanwhile
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,1,1,32'hffffffff,0,1,32'h0, OUT,32'h00100093,32'h80000008,3,3));
    vq.push_back(mk(0,0,0,32'h0,1,0,32'h0, NPC,32'h00100093,32'h80000008,3,3));
    // jump to a misaligned target
    vq.push_back(mk(0,0,0,32'h0,0,1,32'h80001002, REQ,32'h00100093,32'h80001002,3,3));
    vq.push_back(mk(0,1,0,32'h0,0,0,32'h0, RSP,32'h00100093,32'h80001002,3,3));
    vq.push_back(mk(0,0,0,32'h0,0,1,32'h12345678, RSP,32'h00100093,32'h80001002,3,4));
    vq.push_back(mk(0,0,1,32'h00000517,0,0,32'h0, OUT,32'h00000517,32'h80001002,4,4));
    vq.push_back(mk(0,0,0,32'h0,1,0,32'h0, NPC,32'h00000517,32'h80001002,4,4));
    vq.push_back(mk(0,0,0,32'h0,0,0,32'h0, NPC,32'h00000517,32'h80001002,4,4));
    vq.push_back(mk(0,0,0,32'h0,0,1,32'h80001006, REQ,32'h00000517,32'h80001006,4,4));
    // reset while in S_RESP with rvalid high
    vq.push_back(mk(0,1,0,32'h0,0,0,32'h0, RSP,32'h00000517,32'h80001006,4,4));
    vq.push_back(mk(1,1,1,32'h0badf00d,0,0,32'h0, REQ,32'h0,BASE,0,0));
    vq.push_back(mk(0,0,1,32'h0badf00d,0,0,32'h0, REQ,32'h0,BASE,0,1));
    vq.push_back(mk(0,1,0,32'h0,0,0,32'h0, RSP,32'h0,BASE,0,1));
    vq.push_back(mk(0,0,1,32'h13,0,0,32'h0, OUT,32'h13,BASE,1,1));

    foreach (vq[i]) begin
      rst = vq[i].rst;
      ifu_arready = vq[i].ar;
      ifu_rvalid = vq[i].rv;
      ifu_rdata = vq[i].rdata;
      out_ready = vq[i].ordy;
      dnpc_valid = vq[i].dv;
      dnpc = vq[i].dnpc;
      @(posedge clk);
      #1;
      chk("arvalid", i, 32'(ifu_arvalid), 32'(vq[i].st == REQ));
      chk("rready", i, 32'(ifu_rready), 32'(vq[i].st == RSP));
      chk("out_valid", i, 32'(out_valid), 32'(vq[i].st == OUT));
      chk("dnpc_ready", i, 32'(dnpc_ready), 32'(vq[i].st == NPC));
      chk("araddr", i, ifu_araddr, {vq[i].pc[31:2], 2'b00});
      chk("inst", i, inst, vq[i].inst);
      chk("pc", i, pc, vq[i].pc);
      chk("perf_fetch", i, perf_fetch, PERF ? 32'(vq[i].f) : 32'h0);
      chk("perf_stall", i, perf_stall, PERF ? 32'(vq[i].s) : 32'h0);
    end

    // ten instructions with every handshake first-cycle
    begin
      int ov_cnt;
      ov_cnt = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ifu_arready = 1'b1;
      ifu_rvalid = 1'b1;
      ifu_rdata = 32'h13;
      out_ready = 1'b1;
      dnpc_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        chk("loop_araddr", 100 + k, ifu_araddr, BASE + 32'(4 * k));
        for (int c = 0; c < 4; c++) begin
          dnpc = BASE + 32'(4 * (k + 1));
          @(posedge clk);
          #1;
          if (out_valid) ov_cnt++;
        end
      end
      chk("loop_out_valid_cycles", 110, 32'(ov_cnt), 32'd10);
      chk("loop_pc", 111, pc, 32'h80000028);
      chk("loop_arvalid", 112, 32'(ifu_arvalid), 32'd1);
      chk("loop_perf_fetch", 113, perf_fetch, PERF ? 32'd10 : 32'h0);
      chk("loop_perf_stall", 114, perf_stall, 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
